prefix_adder_pipe: RTL and testbench

- Parametrised, pipelined Brent-Kung prefix adder/subtractor with a valid/ready stream interface. It supersedes the fixed 12-bit combinational adder generation.
- Adds WIDTH, a carry-in, subtract mode, signed-overflow flag, a tag passthrough and configurable register depth.
- Sits between operand-staging logic and result consumers in the arithmetic datapath. Operand packing is unchanged from the previous generation: interleaved a/b bit pairs.

---
 rtl/prefix_adder_pipe.sv | 226 ++++++++++++++++++++++
 tb/tb_prefix_adder_pipe.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_adder_pipe.sv
// Pipelined Brent-Kung prefix adder/subtractor with a valid/ready stream interface.
// Operands arrive interleaved (bit 2i = a[i], bit 2i+1 = b[i]). The carry tree is
// split across PIPE_STAGES register stages. The final stage registers the sum,
// carry-out, overflow and tag. Flow control collapses bubbles: a stage can load
// whenever the stage after it is empty or is itself moving on.
module prefix_adder_pipe #(
    parameter int WIDTH       = 12,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] in_operands,
    input  logic               in_cin,
    input  logic               in_sub,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH:0]     out_sum,
    output logic               out_ovf,
    output logic [TAG_W-1:0]   out_tag
);

    // Tree geometry. The operand is padded up to a power of two (N). Pad bits
    // carry g = p = 0, so they never disturb the real carries.
    localparam int LOG_N = $clog2(WIDTH);
    localparam int N     = 1 << LOG_N;
    localparam int L     = 2 * LOG_N - 1;
    localparam int S     = PIPE_STAGES;

    // Last tree level evaluated by stage s. Register k sits after level
    // ceil(k*L/S), and the final stage finishes the tree.
    function automatic int level_hi(input int s);
        if (s >= S - 1) begin
            return L;
        end
        return ((s + 1) * L + S - 1) / S;
    endfunction

    // One Brent-Kung level. Levels 1..LOG_N form the up-sweep. Levels
    // LOG_N+1..L form the down-sweep, which fills in the remaining prefixes.
    // Every read uses the level inputs, so node order within a level does not matter.
    function automatic logic [2*N-1:0] bk_level(input logic [N-1:0] g_in,
                                                input logic [N-1:0] p_in,
                                                input int           lvl);
        logic [N-1:0] g_out;
        logic [N-1:0] p_out;
        int           dl;
        int           step;
        int           d;
        g_out = g_in;
        p_out = p_in;
        dl    = (lvl <= LOG_N) ? lvl : (2 * LOG_N - lvl);
        step  = 1 << dl;
        d     = step >> 1;
        for (int i = 0; i < N; i++) begin
            if (lvl <= LOG_N) begin
                if (((i + 1) % step) == 0) begin
                    g_out[i] = g_in[i] | (p_in[i] & g_in[i-d]);
                    p_out[i] = p_in[i] & p_in[i-d];
                end
            end else if ((i >= step) && (((i + 1) % step) == d)) begin
                g_out[i] = g_in[i] | (p_in[i] & g_in[i-d]);
                p_out[i] = p_in[i] & p_in[i-d];
            end
        end
        return {g_out, p_out};
    endfunction

    // Inputs to each stage's combinational slice of the tree:
    // prefix generate, prefix propagate, raw half-sum bits, carry-in and tag.
    logic [N-1:0]     st_g   [S];
    logic [N-1:0]     st_p   [S];
    logic [WIDTH-1:0] st_hp  [S];
    logic             st_c0  [S];
    logic [TAG_W-1:0] st_tag [S];

    logic [S-1:0] vld_reg;
    logic [S-1:0] adv;
    logic [S-1:0] inc_vld;
    logic [S-1:0] load;
    logic         run_reg;
    logic         accept;

    // Operand unpacking and bit-level generate/propagate.
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] hp0;
    logic [WIDTH-1:0] g_fold;
    logic             c0_in;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_unpack
        assign op_a[gi] = in_operands[2*gi];
        assign op_b[gi] = in_operands[2*gi+1];
    end

    // Subtract inverts b and forces carry-in to 1. The carry-in is folded into
    // bit 0's generate, so each prefix generate equals the carry into the next bit.
    always_comb begin
        c0_in     = in_sub | in_cin;
        b_eff     = op_b ^ {WIDTH{in_sub}};
        hp0       = op_a ^ b_eff;
        g_fold    = op_a & b_eff;
        g_fold[0] = g_fold[0] | (hp0[0] & c0_in);
    end

    assign st_g[0]   = N'(g_fold);
    assign st_p[0]   = N'(hp0);
    assign st_hp[0]  = hp0;
    assign st_c0[0]  = c0_in;
    assign st_tag[0] = in_tag;

    // Backward ready chain: a stage advances when it is empty or its successor advances.
    always_comb begin
        adv[S-1] = ~vld_reg[S-1] | out_ready;
        for (int s = S - 2; s >= 0; s--) begin
            adv[s] = ~vld_reg[s] | adv[s+1];
        end
    end

    // Valid bit arriving at each stage.
    always_comb begin
        inc_vld[0] = accept;
        for (int s = 1; s < S; s++) begin
            inc_vld[s] = vld_reg[s-1];
        end
    end

    assign in_ready  = run_reg & adv[0];
    assign accept    = in_valid & in_ready;
    assign load      = adv & inc_vld;
    assign out_valid = vld_reg[S-1];

    // Stage valid bits. run_reg holds in_ready low during reset and for the
    // release edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg <= '0;
            run_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            for (int s = 0; s < S; s++) begin
                if (adv[s]) begin
                    vld_reg[s] <= inc_vld[s];
                end
            end
        end
    end

    for (genvar gi = 0; gi < S; gi++) begin : g_stage
        localparam int LO = (gi == 0) ? 0 : level_hi(gi - 1);
        localparam int HI = level_hi(gi);

        logic [N-1:0] lvl_g;
        logic [N-1:0] lvl_p;

        // Evaluate this stage's share of the tree levels.
        always_comb begin
            lvl_g = st_g[gi];
            lvl_p = st_p[gi];
            for (int l = LO + 1; l <= HI; l++) begin
                {lvl_g, lvl_p} = bk_level(lvl_g, lvl_p, l);
            end
        end

        if (gi < S - 1) begin : g_mid
            logic [N-1:0]     g_reg;
            logic [N-1:0]     p_reg;
            logic [WIDTH-1:0] hp_reg;
            logic             c0_reg;
            logic [TAG_W-1:0] tag_reg;

            // Intermediate register: partial prefixes plus what the sum stage needs.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    g_reg   <= '0;
                    p_reg   <= '0;
                    hp_reg  <= '0;
                    c0_reg  <= 1'b0;
                    tag_reg <= '0;
                end else if (load[gi]) begin
                    g_reg   <= lvl_g;
                    p_reg   <= lvl_p;
                    hp_reg  <= st_hp[gi];
                    c0_reg  <= st_c0[gi];
                    tag_reg <= st_tag[gi];
                end
            end

            assign st_g[gi+1]   = g_reg;
            assign st_p[gi+1]   = p_reg;
            assign st_hp[gi+1]  = hp_reg;
            assign st_c0[gi+1]  = c0_reg;
            assign st_tag[gi+1] = tag_reg;
        end else begin : g_last
            logic [WIDTH:0]   carry;
            logic [WIDTH-1:0] sum_next;
            logic             ovf_next;

            // carry[i] is the carry into bit i. carry[WIDTH] is the carry-out.
            always_comb begin
                carry    = {lvl_g[WIDTH-1:0], st_c0[gi]};
                sum_next = st_hp[gi] ^ carry[WIDTH-1:0];
                ovf_next = carry[WIDTH] ^ carry[WIDTH-1];
            end

            // Output register. It only loads when the consumer can take it,
            // so a stalled result holds steady.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_sum <= '0;
                    out_ovf <= 1'b0;
                    out_tag <= '0;
                end else if (load[gi]) begin
                    out_sum <= {carry[WIDTH], sum_next};
                    out_ovf <= ovf_next;
                    out_tag <= st_tag[gi];
                end
            end
        end
    end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Scoreboard bench for prefix_adder_pipe across a sweep of WIDTH / PIPE_STAGES.
// Each configuration has its own DUT, reset, stimulus process and monitor.
// The stimulus pushes expected results when an op is accepted. The monitor
// pops and compares them when the DUT hands a result over.
module tb_prefix_adder_pipe;

    localparam int TB_TAG_W = 4;
    localparam int NCFG     = 11;

    function automatic int cfg_w(input int i);
        case (i)
            0:       return 12;
            1:       return 2;
            2:       return 2;
            3:       return 12;
            4:       return 12;
            5:       return 13;
            6:       return 13;
            7:       return 32;
            8:       return 32;
            9:       return 64;
            default: return 64;
        endcase
    endfunction

    function automatic int cfg_s(input int i);
        case (i)
            0:       return 2;
            1, 3, 5, 7, 9: return 1;
            default: return 4;
        endcase
    endfunction

    logic clk;
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   n_done;

    initial begin
        clk    = 1'b0;
        cyc    = 0;
        n_cmp  = 0;
        n_err  = 0;
        n_done = 0;
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int W = cfg_w(gi);
        localparam int S = cfg_s(gi);

        typedef struct packed {
            logic [W:0]          sum;
            logic                ovf;
            logic [TB_TAG_W-1:0] tag;
            logic [31:0]         acc;
            logic                lat;
        } exp_t;

        logic                rst_n;
        logic                in_valid;
        logic                in_ready;
        logic [2*W-1:0]      in_operands;
        logic                in_cin;
        logic                in_sub;
        logic [TB_TAG_W-1:0] in_tag;
        logic                out_valid;
        logic                out_ready;
        logic [W:0]          out_sum;
        logic                out_ovf;
        logic [TB_TAG_W-1:0] out_tag;
        int                  rdy_mode;
        exp_t                exp_q[$];

        prefix_adder_pipe #(
            .WIDTH      (W),
            .PIPE_STAGES(S),
            .TAG_W      (TB_TAG_W)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid),
            .in_ready   (in_ready),
            .in_operands(in_operands),
            .in_cin     (in_cin),
            .in_sub     (in_sub),
            .in_tag     (in_tag),
            .out_valid  (out_valid),
            .out_ready  (out_ready),
            .out_sum    (out_sum),
            .out_ovf    (out_ovf),
            .out_tag    (out_tag)
        );

        // Reference: (a + b' + c0) mod 2^(W+1). Overflow is derived from the
        // operand and result signs.
        function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                                   input logic cin, input logic sub);
            logic [W-1:0] bb;
            logic [W:0]   s;
            logic         ov;
            bb = sub ? ~b : b;
            s  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub | cin)};
            ov = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
            return {ov, s};
        endfunction

        function automatic logic [W-1:0] rnd_val();
            logic [63:0]  r;
            logic [W-1:0] v;
            r = {$urandom(), $urandom()};
            case ($urandom_range(0, 7))
                0:       v = '1;
                1:       v = '0;
                2:       v = {1'b0, {(W-1){1'b1}}};
                3:       v = {1'b1, {(W-1){1'b0}}};
                default: v = r[W-1:0];
            endcase
            return v;
        endfunction

        // out_ready driver: 0 = held low, 1 = held high, 2 = random.
        initial begin
            out_ready = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                case (rdy_mode)
                    0:       out_ready = 1'b0;
                    1:       out_ready = 1'b1;
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
            end
        end

        // Offer one op, starting just after a rising edge. The expected result
        // is pushed at the cycle it is accepted.
        task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                             input logic sub, input logic [TB_TAG_W-1:0] tag,
                             input logic [W:0] esum, input logic eovf, input int max_wait,
                             input bit lat, input bit must_take, output bit taken);
            logic [2*W-1:0] ops;
            exp_t           e;
            for (int i = 0; i < W; i++) begin
                ops[2*i]   = a[i];
                ops[2*i+1] = b[i];
            end
            in_operands = ops;
            in_cin      = cin;
            in_sub      = sub;
            in_tag      = tag;
            in_valid    = 1'b1;
            taken       = 1'b0;
            for (int w = 0; w < max_wait && !taken; w++) begin
                @(negedge clk);
                if (in_ready) begin
                    taken = 1'b1;
                    e.sum = esum;
                    e.ovf = eovf;
                    e.tag = tag;
                    e.acc = 32'(cyc);
                    e.lat = lat;
                    exp_q.push_back(e);
                end
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            if (must_take) begin
                n_cmp++;
                if (!taken) begin
                    n_err++;
                    $display("FAIL cfg%0d accept_timeout: in_ready got 0 want 1 within %0d cycles (tag %h)",
                             gi, max_wait, tag);
                end
            end
        endtask

        task automatic rnd_op(input logic [TB_TAG_W-1:0] tag, input bit lat, input int max_wait);
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         cin;
            logic         sub;
            logic [W+1:0] r;
            bit           tk;
            a   = rnd_val();
            b   = rnd_val();
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            r   = ref_model(a, b, cin, sub);
            offer(a, b, cin, sub, tag, r[W:0], r[W+1], max_wait, lat, 1'b1, tk);
        endtask

        task automatic wait_drain();
            for (int w = 0; w < 400 && exp_q.size() != 0; w++) begin
                @(posedge clk);
                #1;
            end
            n_cmp++;
            if (exp_q.size() != 0) begin
                n_err++;
                $display("FAIL cfg%0d drain_timeout: pending got %0d want 0", gi, exp_q.size());
            end
        endtask

        task automatic set_mode(input int m);
            rdy_mode = m;
            repeat (2) begin
                @(posedge clk);
                #1;
            end
        endtask

        task automatic expect_bit(input string name, input logic got, input logic want);
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL cfg%0d %s: got %b want %b", gi, name, got, want);
            end
        endtask

        // Monitor: compare each handed-over result against the queue head, and
        // check that a stalled result holds steady.
        initial begin : monitor
            logic [W+TB_TAG_W+1:0] hold_val;
            bit                    hold_vld;
            exp_t                  e;
            hold_vld = 1'b0;
            hold_val = '0;
            forever begin
                @(negedge clk);
                if (rst_n !== 1'b1) begin
                    hold_vld = 1'b0;
                    continue;
                end
                if (hold_vld && out_valid) begin
                    n_cmp++;
                    if ({out_sum, out_ovf, out_tag} !== hold_val) begin
                        n_err++;
                        $display("FAIL cfg%0d hold_stable: got %h want %h", gi,
                                 {out_sum, out_ovf, out_tag}, hold_val);
                    end
                end
                hold_vld = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL cfg%0d unexpected_result: got sum %h tag %h want none", gi, out_sum, out_tag);
                    end else begin
                        e = exp_q.pop_front();
                        n_cmp += 3;
                        if (out_sum !== e.sum) begin
                            n_err++;
                            $display("FAIL cfg%0d sum: got %h want %h (tag %h)", gi, out_sum, e.sum, e.tag);
                        end
                        if (out_ovf !== e.ovf) begin
                            n_err++;
                            $display("FAIL cfg%0d ovf: got %b want %b (tag %h)", gi, out_ovf, e.ovf, e.tag);
                        end
                        if (out_tag !== e.tag) begin
                            n_err++;
                            $display("FAIL cfg%0d tag: got %h want %h", gi, out_tag, e.tag);
                        end
                        if (e.lat) begin
                            n_cmp++;
                            if (cyc - int'(e.acc) != S) begin
                                n_err++;
                                $display("FAIL cfg%0d latency: got %0d want %0d", gi, cyc - int'(e.acc), S);
                            end
                        end
                        $display("cfg%0d W=%0d S=%0d tag=%h sum=%h ovf=%b", gi, W, S, out_tag, out_sum, out_ovf);
                    end
                end else if (out_valid) begin
                    hold_vld = 1'b1;
                    hold_val = {out_sum, out_ovf, out_tag};
                end
            end
        end

        initial begin : stim
            logic [W:0]   one;
            logic [W-1:0] ones;
            logic [W-1:0] maxpos;
            logic [W-1:0] minneg;
            logic [W-1:0] zero;
            logic [W-1:0] unit;
            bit           tk;
            int           n_taken;
            int           c_start;

            one    = 1;
            ones   = '1;
            maxpos = ones >> 1;
            minneg = ~maxpos;
            zero   = '0;
            unit   = 1;

            rdy_mode    = 0;
            rst_n       = 1'b0;
            in_valid    = 1'b0;
            in_operands = '0;
            in_cin      = 1'b0;
            in_sub      = 1'b0;
            in_tag      = '0;
            #1;
            expect_bit("reset_out_valid", out_valid, 1'b0);
            expect_bit("reset_in_ready", in_ready, 1'b0);
            expect_bit("reset_out_ovf", out_ovf, 1'b0);
            n_cmp += 2;
            if (out_sum !== '0) begin
                n_err++;
                $display("FAIL cfg%0d reset_out_sum: got %h want 0", gi, out_sum);
            end
            if (out_tag !== '0) begin
                n_err++;
                $display("FAIL cfg%0d reset_out_tag: got %h want 0", gi, out_tag);
            end
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            set_mode(1);

            // Width-generic directed vectors.
            offer(ones, unit, 1'b0, 1'b0, 4'h1, one << W, 1'b0, 20, 1'b1, 1'b1, tk);
            offer(maxpos, zero, 1'b1, 1'b0, 4'h2, one << (W - 1), 1'b1, 20, 1'b1, 1'b1, tk);
            offer(zero, unit, 1'b0, 1'b1, 4'h8, (one << W) - 1, 1'b0, 20, 1'b1, 1'b1, tk);
            offer(minneg, unit, 1'b0, 1'b1, 4'h9, (one << W) | {1'b0, maxpos}, 1'b1, 20, 1'b1, 1'b1, tk);

            // Hand-worked 12-bit vectors.
            if (W == 12) begin
                offer(W'(12'hFFF), W'(12'h001), 1'b0, 1'b0, 4'h3, (W+1)'(13'h1000), 1'b0, 20, 1'b1, 1'b1, tk);
                offer(W'(12'h005), W'(12'h007), 1'b0, 1'b1, 4'h4, (W+1)'(13'h0FFE), 1'b0, 20, 1'b1, 1'b1, tk);
                offer(W'(12'h800), W'(12'h001), 1'b0, 1'b1, 4'h5, (W+1)'(13'h17FF), 1'b1, 20, 1'b1, 1'b1, tk);
                offer(W'(12'h7FF), W'(12'h000), 1'b1, 1'b0, 4'h6, (W+1)'(13'h0800), 1'b1, 20, 1'b1, 1'b1, tk);
                offer(W'(12'h7FF), W'(12'h000), 1'b1, 1'b1, 4'h7, (W+1)'(13'h17FF), 1'b0, 20, 1'b1, 1'b1, tk);
            end
            wait_drain();

            // Streaming: 100 back-to-back ops should take exactly 100 cycles.
            c_start = cyc;
            for (int i = 0; i < 100; i++) begin
                rnd_op(TB_TAG_W'(i), 1'b1, 20);
            end
            n_cmp++;
            if (cyc - c_start != 100) begin
                n_err++;
                $display("FAIL cfg%0d stream_cycles: got %0d want 100", gi, cyc - c_start);
            end
            wait_drain();

            // Backpressure: with out_ready low only S ops fit.
            set_mode(0);
            n_taken = 0;
            for (int i = 0; i < 5; i++) begin
                logic [W+1:0] r;
                logic [W-1:0] a;
                logic [W-1:0] b;
                a = rnd_val();
                b = rnd_val();
                r = ref_model(a, b, 1'b0, 1'b0);
                offer(a, b, 1'b0, 1'b0, TB_TAG_W'(i + 10), r[W:0], r[W+1], 1, 1'b0, 1'b0, tk);
                if (tk) n_taken++;
            end
            n_cmp++;
            if (n_taken != S) begin
                n_err++;
                $display("FAIL cfg%0d bp_accepted: got %0d want %0d", gi, n_taken, S);
            end
            @(negedge clk);
            expect_bit("bp_in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
            set_mode(1);
            wait_drain();

            // Reset with ops in flight: they must vanish.
            set_mode(0);
            for (int i = 0; i < S; i++) begin
                rnd_op(TB_TAG_W'(i), 1'b0, 1);
            end
            #2;
            rst_n = 1'b0;
            #1;
            expect_bit("rst_out_valid", out_valid, 1'b0);
            expect_bit("rst_in_ready", in_ready, 1'b0);
            exp_q.delete();
            rdy_mode = 1;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk);
            @(negedge clk);
            expect_bit("post_rst_in_ready", in_ready, 1'b1);
            expect_bit("post_rst_out_valid", out_valid, 1'b0);
            repeat (S + 3) @(posedge clk);
            #1;

            // Random out_ready over 1000 ops.
            set_mode(2);
            for (int i = 0; i < 1000; i++) begin
                rnd_op(TB_TAG_W'(i), 1'b0, 200);
            end
            set_mode(1);
            wait_drain();
            n_done++;
        end
    end

    initial begin : finisher
        while (n_done < NCFG && cyc < 90000) @(posedge clk);
        if (n_done < NCFG) begin
            n_cmp++;
            n_err++;
            $display("FAIL global_timeout: finished configs got %0d want %0d", n_done, NCFG);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
